div_dispatch_scheduler: RTL and testbench
=========================================

Name: div_dispatch_scheduler

Overview:
Front-end scheduler for the pool of inverse-divider clusters. It accepts untagged direction payloads over a valid/ready handshake and stamps each with a monotonically increasing tag. It dispatches each payload to one idle cluster, chosen round-robin, with a one-cycle start pulse. It limits in-flight work to the reorder buffer capacity through a retire-driven credit count, and provides a drain/quiesce sequence for flush and reconfiguration.

Parameters:
DIV_COUNT, 16, number of divider clusters served
TAG_SIZE, 48, tag width; tag counter wraps modulo 2^TAG_SIZE
DATA_W, 96, payload width (X,Y,Z at 32 bits each)
MAX_INFLIGHT, 32, reorder buffer depth; maximum tags issued but not retired

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  upstream payload valid
req_ready  out  1  scheduler accepts payload this cycle
req_data  in  DATA_W  payload
div_ready  in  DIV_COUNT  per-cluster idle flag
div_start  out  DIV_COUNT  one-hot start pulse, registered
div_data  out  DATA_W  payload to all clusters, registered
div_tag  out  TAG_SIZE  tag of the dispatched payload, registered
retire  in  1  one result popped from the reorder buffer (returns one credit)
drain_req  in  1  level; stop accepting and wait for in-flight work to reach zero
drain_done  out  1  one-cycle pulse when drain completes
inflight  out  $clog2(MAX_INFLIGHT+1)  issued but not yet retired count
retire_err  out  1  sticky; retire seen while inflight==0

Behaviour:
- Everything is on clk. reset is synchronous and active-high.
- Reset values:
  - state=RUN; req_ready=0 during the reset cycle
  - div_start=0, div_data=0, div_tag=0
  - tag counter=0, inflight=0, drain_done=0, retire_err=0
  - RR pointer=0 (cluster 0 has highest priority)
- Reset mid-operation discards everything in flight. The scheduler does not wait for clusters.
- Cluster availability: avail = div_ready & ~div_start. The start register masks the cluster granted last cycle, because that cluster's ready flag has not yet fallen.
- req_ready = (state==RUN) & (inflight<MAX_INFLIGHT) & |avail. req_ready is combinational from registered state and div_ready. It never depends on req_valid.
- Accept happens at the clock edge where req_valid & req_ready. On that edge:
  - div_start <= onehot(g), where g is the first set bit of avail searched from the RR pointer upward, wrapping modulo DIV_COUNT
  - div_data <= req_data; div_tag <= tag counter
  - tag counter increments, wrapping 2^TAG_SIZE-1 -> 0
  - RR pointer <= (g+1) mod DIV_COUNT
- Latency is 1: start is visible the cycle after acceptance, for exactly one cycle. On cycles with no accept, div_start=0. div_data and div_tag hold their last values.
- Throughput: one accept per cycle while avail has enough bits set.
- inflight: +1 on accept, -1 on retire. Simultaneous accept and retire leaves it unchanged.
- retire with inflight==0 does not decrement (no underflow) and sets retire_err, which stays set until reset.
- States:
  - RUN: normal operation. drain_req=1 -> DRAIN.
  - DRAIN: req_ready=0. A request presented on the same edge that drain_req is sampled is still accepted if req_ready was 1 on that edge. When inflight==0 (including any retire on that cycle) -> DONE.
  - DONE: drain_done=1 for one cycle. The next state is HOLD if drain_req is still 1, otherwise RUN.
  - HOLD: req_ready=0. drain_req=0 -> RUN.
- The tag counter and RR pointer are preserved across drain. Only reset clears them.
- Boundaries:
  - inflight==MAX_INFLIGHT forces req_ready=0; a retire that cycle allows acceptance the following cycle.
  - All clusters busy forces req_ready=0.
  - A single available cluster is re-granted no more often than every other cycle because of the start mask.

Test Plan:
- Reset, DIV_COUNT=4, all div_ready=1, req_valid held for 4 cycles with data 1..4 -> div_start sequence 0001, 0010, 0100, 1000; div_tag 0,1,2,3; inflight 4; each start one cycle after its accept.
- Only cluster 2 ready (div_ready=0100 constant), req_valid held -> accepts on alternating cycles; div_start=0100 every other cycle; req_ready low in each cycle following a grant.
- MAX_INFLIGHT=2, no retire, 3 requests -> third stalls with req_ready=0. Pulse retire -> third accepted the next cycle with tag 2; inflight back to 2.
- Accept and retire on the same cycle at inflight=1 -> inflight stays 1. retire at inflight=0 -> retire_err=1, inflight stays 0.
- 3 in flight, assert drain_req -> req_ready=0. After 3 retires, drain_done pulses one cycle later. Hold drain_req=1 -> HOLD, still blocked. Release -> next accept carries tag 3 and RR continues from the saved pointer.
- Preset tag counter to 2^TAG_SIZE-1 (TAG_SIZE=4: 15), two accepts -> tags 15 then 0. Assert reset mid-stream -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/div_dispatch_scheduler.sv
// Front-end scheduler for the inverse-divider cluster pool: tags each accepted payload,
// issues it to one idle cluster (round-robin), bounds in-flight work by retire credits, and drains on request.
module div_dispatch_scheduler #(
    parameter int DIV_COUNT    = 16,
    parameter int TAG_SIZE     = 48,
    parameter int DATA_W       = 96,
    parameter int MAX_INFLIGHT = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [DATA_W-1:0]                 req_data,
    input  logic [DIV_COUNT-1:0]              div_ready,
    output logic [DIV_COUNT-1:0]              div_start,
    output logic [DATA_W-1:0]                 div_data,
    output logic [TAG_SIZE-1:0]               div_tag,
    input  logic                              retire,
    input  logic                              drain_req,
    output logic                              drain_done,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                              retire_err
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int PTR_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE, S_HOLD} state_t;

    state_t               r_state;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [TAG_SIZE-1:0]  r_tag;
    logic [CNT_W-1:0]     r_inflight;
    logic [DIV_COUNT-1:0] r_div_start;
    logic [DATA_W-1:0]    r_div_data;
    logic [TAG_SIZE-1:0]  r_div_tag;
    logic                 r_drain_done;
    logic                 r_retire_err;

    logic [DIV_COUNT-1:0] w_avail;
    logic                 w_req_ready;
    logic                 w_accept;
    logic                 w_retire_ok;
    logic [CNT_W-1:0]     w_inflight_nxt;
    logic                 w_grant_found;
    logic [PTR_W-1:0]     w_grant_idx;
    logic [PTR_W-1:0]     w_scan_idx;
    int                   w_scan_pos;
    logic [PTR_W-1:0]     w_ptr_nxt;
    logic [DIV_COUNT-1:0] w_grant_onehot;

    // A cluster granted last cycle still shows ready, so the start register masks it.
    assign w_avail        = div_ready & ~r_div_start;
    assign w_req_ready    = ~reset & (r_state == S_RUN) &
                            (r_inflight < CNT_W'(MAX_INFLIGHT)) & (|w_avail);
    assign w_accept       = req_valid & w_req_ready;
    assign w_retire_ok    = retire & (r_inflight != '0);
    assign w_inflight_nxt = r_inflight + CNT_W'(w_accept) - CNT_W'(w_retire_ok);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_scan_pos    = 0;
        w_scan_idx    = '0;
        for (int i = 0; i < DIV_COUNT; i++) begin
            w_scan_pos = int'(r_rr_ptr) + i;
            if (w_scan_pos >= DIV_COUNT) w_scan_pos = w_scan_pos - DIV_COUNT;
            w_scan_idx = PTR_W'(w_scan_pos);
            if (!w_grant_found && w_avail[w_scan_idx]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_scan_idx;
            end
        end
    end

    assign w_ptr_nxt      = (w_grant_idx == PTR_W'(DIV_COUNT - 1)) ? '0 : w_grant_idx + PTR_W'(1);
    assign w_grant_onehot = DIV_COUNT'(1) << w_grant_idx;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_RUN;
            r_rr_ptr     <= '0;
            r_tag        <= '0;
            r_inflight   <= '0;
            r_div_start  <= '0;
            r_div_data   <= '0;
            r_div_tag    <= '0;
            r_drain_done <= 1'b0;
            r_retire_err <= 1'b0;
        end else begin
            r_inflight   <= w_inflight_nxt;
            r_div_start  <= w_accept ? w_grant_onehot : '0;
            r_drain_done <= 1'b0;
            if (retire && r_inflight == '0) r_retire_err <= 1'b1;
            if (w_accept) begin
                r_div_data <= req_data;
                r_div_tag  <= r_tag;
                r_tag      <= r_tag + TAG_SIZE'(1);
                r_rr_ptr   <= w_ptr_nxt;
            end
            case (r_state)
                S_RUN:   if (drain_req) r_state <= S_DRAIN;
                S_DRAIN: if (w_inflight_nxt == '0) begin
                    r_state      <= S_DONE;
                    r_drain_done <= 1'b1;
                end
                S_DONE:  r_state <= drain_req ? S_HOLD : S_RUN;
                S_HOLD:  if (!drain_req) r_state <= S_RUN;
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign req_ready  = w_req_ready;
    assign div_start  = r_div_start;
    assign div_data   = r_div_data;
    assign div_tag    = r_div_tag;
    assign drain_done = r_drain_done;
    assign inflight   = r_inflight;
    assign retire_err = r_retire_err;

endmodule

// File: tb/tb_div_dispatch_scheduler.sv
// Self-checking bench for div_dispatch_scheduler (4 clusters, 4-bit tags, 4-deep credit pool).
// Dispatch outputs are checked through a scoreboard queue filled when each accept is expected.
module tb_div_dispatch_scheduler;

    localparam int DC = 4;
    localparam int TS = 4;
    localparam int DW = 16;
    localparam int MI = 4;
    localparam int CW = $clog2(MI + 1);

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_data;
    logic [DC-1:0] div_ready;
    logic [DC-1:0] div_start;
    logic [DW-1:0] div_data;
    logic [TS-1:0] div_tag;
    logic          retire;
    logic          drain_req;
    logic          drain_done;
    logic [CW-1:0] inflight;
    logic          retire_err;

    div_dispatch_scheduler #(
        .DIV_COUNT(DC), .TAG_SIZE(TS), .DATA_W(DW), .MAX_INFLIGHT(MI)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .div_ready(div_ready), .div_start(div_start), .div_data(div_data), .div_tag(div_tag),
        .retire(retire), .drain_req(drain_req), .drain_done(drain_done),
        .inflight(inflight), .retire_err(retire_err)
    );

    typedef struct packed {
        logic [DC-1:0] start;
        logic [DW-1:0] data;
        logic [TS-1:0] tag;
    } exp_t;

    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] last_data = '0;
    logic [TS-1:0] last_tag  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock: queue the expected dispatch (if any), then compare the registered outputs.
    task automatic tick(input bit acc, input logic [DC-1:0] st, input logic [TS-1:0] tg);
        exp_t e;
        if (acc) exp_q.push_back('{start: st, data: req_data, tag: tg});
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (acc) begin
            e = exp_q.pop_front();
            if (div_start !== e.start || div_data !== e.data || div_tag !== e.tag)
                $display("FAIL dispatch: start=%b data=%h tag=%0d expected start=%b data=%h tag=%0d",
                         div_start, div_data, div_tag, e.start, e.data, e.tag);
            else n_pass++;
            last_data = e.data;
            last_tag  = e.tag;
        end else begin
            if (div_start !== '0 || div_data !== last_data || div_tag !== last_tag)
                $display("FAIL idle_hold: start=%b data=%h tag=%0d expected start=0000 data=%h tag=%0d",
                         div_start, div_data, div_tag, last_data, last_tag);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_data = '0; div_ready = 4'hF;
        retire = 1'b0; drain_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0 || div_start !== '0 || div_data !== '0 || div_tag !== '0 ||
            inflight !== '0 || drain_done !== 1'b0 || retire_err !== 1'b0)
            $display("FAIL reset_state: rdy=%b start=%b data=%h tag=%0d infl=%0d done=%b err=%b expected all 0",
                     req_ready, div_start, div_data, div_tag, inflight, drain_done, retire_err);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL ready_after_reset: req_ready=%b expected 1", req_ready);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        req_valid = 1'b1;
        req_data = 16'h0001; tick(1, 4'b0001, 4'd0);
        req_data = 16'h0002; tick(1, 4'b0010, 4'd1);
        req_data = 16'h0003; tick(1, 4'b0100, 4'd2);
        req_data = 16'h0004; tick(1, 4'b1000, 4'd3);
        req_valid = 1'b0;
        n_checks++;
        if (inflight !== CW'(4)) $display("FAIL rr_inflight: inflight=%0d expected 4", inflight);
        else n_pass++;
    endtask

    task automatic test_credit_limit();
        req_valid = 1'b1; req_data = 16'h0005;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) $display("FAIL full_blocks: req_ready=%b expected 0", req_ready);
        else n_pass++;
        tick(0, '0, '0);
        retire = 1'b1;
        tick(0, '0, '0);
        retire = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || inflight !== CW'(3))
            $display("FAIL credit_return: req_ready=%b inflight=%0d expected 1 and 3", req_ready, inflight);
        else n_pass++;
        tick(1, 4'b0001, 4'd4);
        req_valid = 1'b0;
        n_checks++;
        if (inflight !== CW'(4)) $display("FAIL credit_refill: inflight=%0d expected 4", inflight);
        else n_pass++;
        retire = 1'b1;
        repeat (4) tick(0, '0, '0);
        retire = 1'b0;
        n_checks++;
        if (inflight !== '0 || retire_err !== 1'b0)
            $display("FAIL credit_empty: inflight=%0d err=%b expected 0 and 0", inflight, retire_err);
        else n_pass++;
    endtask

    task automatic test_single_cluster();
        div_ready = 4'b0100; req_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_data = 16'h0100 + DW'(k);
            tick(1, 4'b0100, TS'(5 + k));
            #1;
            n_checks++;
            if (req_ready !== 1'b0) $display("FAIL single_mask: req_ready=%b expected 0", req_ready);
            else n_pass++;
            tick(0, '0, '0);
        end
        req_valid = 1'b0;
        div_ready = 4'hF;
    endtask

    task automatic test_retire_collision();
        retire = 1'b1;
        tick(0, '0, '0);
        n_checks++;
        if (inflight !== CW'(1)) $display("FAIL retire_one: inflight=%0d expected 1", inflight);
        else n_pass++;
        req_valid = 1'b1; req_data = 16'h0200;
        tick(1, 4'b1000, 4'd7);
        req_valid = 1'b0;
        n_checks++;
        if (inflight !== CW'(1)) $display("FAIL accept_and_retire: inflight=%0d expected 1", inflight);
        else n_pass++;
        tick(0, '0, '0);
        tick(0, '0, '0);
        retire = 1'b0;
        n_checks++;
        if (inflight !== '0 || retire_err !== 1'b1)
            $display("FAIL underflow: inflight=%0d err=%b expected 0 and 1", inflight, retire_err);
        else n_pass++;
        tick(0, '0, '0);
        n_checks++;
        if (retire_err !== 1'b1) $display("FAIL err_sticky: retire_err=%b expected 1", retire_err);
        else n_pass++;
    endtask

    task automatic test_drain();
        req_valid = 1'b1;
        req_data = 16'h0300; tick(1, 4'b0001, 4'd8);
        req_data = 16'h0301; tick(1, 4'b0010, 4'd9);
        req_data = 16'h0302; drain_req = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL drain_edge_ready: req_ready=%b expected 1", req_ready);
        else n_pass++;
        tick(1, 4'b0100, 4'd10);
        req_data = 16'h0303;
        n_checks++;
        if (req_ready !== 1'b0 || inflight !== CW'(3))
            $display("FAIL drain_blocks: req_ready=%b inflight=%0d expected 0 and 3", req_ready, inflight);
        else n_pass++;
        tick(0, '0, '0);
        retire = 1'b1;
        tick(0, '0, '0);
        tick(0, '0, '0);
        n_checks++;
        if (drain_done !== 1'b0) $display("FAIL drain_early: drain_done=%b expected 0", drain_done);
        else n_pass++;
        tick(0, '0, '0);
        retire = 1'b0;
        n_checks++;
        if (drain_done !== 1'b1 || req_ready !== 1'b0)
            $display("FAIL drain_done: drain_done=%b req_ready=%b expected 1 and 0", drain_done, req_ready);
        else n_pass++;
        tick(0, '0, '0);
        n_checks++;
        if (drain_done !== 1'b0 || req_ready !== 1'b0)
            $display("FAIL hold_state: drain_done=%b req_ready=%b expected 0 and 0", drain_done, req_ready);
        else n_pass++;
        tick(0, '0, '0);
        drain_req = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) $display("FAIL hold_release: req_ready=%b expected 0", req_ready);
        else n_pass++;
        tick(0, '0, '0);
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL run_resume: req_ready=%b expected 1", req_ready);
        else n_pass++;
        tick(1, 4'b1000, 4'd11);
        req_valid = 1'b0;
    endtask

    task automatic test_tag_wrap_and_reset();
        logic [DC-1:0] starts[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [TS-1:0] tags[5]   = '{4'd12, 4'd13, 4'd14, 4'd15, 4'd0};
        req_valid = 1'b1; retire = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_data = 16'h0400 + DW'(k);
            tick(1, starts[k], tags[k]);
        end
        retire = 1'b0;
        n_checks++;
        if (inflight !== CW'(1)) $display("FAIL wrap_inflight: inflight=%0d expected 1", inflight);
        else n_pass++;
        reset = 1'b1;
        last_data = '0;
        last_tag  = '0;
        tick(0, '0, '0);
        n_checks++;
        if (req_ready !== 1'b0 || inflight !== '0 || drain_done !== 1'b0 || retire_err !== 1'b0)
            $display("FAIL midstream_reset: rdy=%b infl=%0d done=%b err=%b expected all 0",
                     req_ready, inflight, drain_done, retire_err);
        else n_pass++;
        reset = 1'b0;
        req_data = 16'h0500;
        tick(1, 4'b0001, 4'd0);
        req_valid = 1'b0;
        n_checks++;
        if (inflight !== CW'(1)) $display("FAIL post_reset_inflight: inflight=%0d expected 1", inflight);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_credit_limit();
        test_single_cluster();
        test_retire_collision();
        test_drain();
        test_tag_wrap_and_reset();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: %0d entries expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
